// File: rtl/multiplier_pkg.sv
// Shared types and width helpers for the sequential shift-add multiplier.
// Contents: FSM state enum, product-width and counter-width helpers.
package multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Product is 2*WIDTH bits of magnitude plus one sign/extension bit.
    function automatic int prod_width(input int width);
        return 2 * width + 1;
    endfunction

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/multiplier_seq.sv
// Sequential shift-add multiplier, one multiplier bit per clock, with a
// valid/ready handshake on both operand and result sides.
// Ports: clk, rst (sync, active-high), in_valid/in_ready, A, B, signed_mode,
//        out_valid/out_ready, ans (2*WIDTH+1 bits, top bit is extension).
// Build option: MULTIPLIER_SEQ_SIGNED_EN enables two's-complement mode;
// without it signed_mode is ignored and every product is unsigned.
module multiplier_seq
    import multiplier_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WIDTH-1:0]                 A,
    input  logic [WIDTH-1:0]                 B,
    input  logic                             signed_mode,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [prod_width(WIDTH)-1:0]     ans
);

    localparam int PW = prod_width(WIDTH);
    localparam int CW = cnt_width(WIDTH);

    state_t state;
    state_t state_next;

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   a_cap;
    logic [WIDTH-1:0]   b_cap;
    logic [PW-1:0]      result;
    logic               calc_last;

`ifdef MULTIPLIER_SEQ_SIGNED_EN
    logic neg;
    logic neg_cap;

    // Magnitudes are captured so the core loop stays unsigned; the most
    // negative value maps to 2^(WIDTH-1), which still fits unsigned.
    assign a_cap   = (signed_mode && A[WIDTH-1]) ? (~A + 1'b1) : A;
    assign b_cap   = (signed_mode && B[WIDTH-1]) ? (~B + 1'b1) : B;
    assign neg_cap = signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
    assign result  = neg ? (~{1'b0, acc} + 1'b1) : {1'b0, acc};

    always_ff @(posedge clk) begin
        if (rst) begin
            neg <= 1'b0;
        end else if (state == IDLE && in_valid) begin
            neg <= neg_cap;
        end
    end
`else
    logic unused_signed_mode;

    assign unused_signed_mode = signed_mode;
    assign a_cap  = A;
    assign b_cap  = B;
    assign result = {1'b0, acc};
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign calc_last = (cnt == CW'(WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (in_valid)  state_next = CALC;
            CALC:    if (calc_last) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The cycle after the last iteration only publishes the product, which
    // keeps latency at WIDTH+1 from the acceptance edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            ans    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        mcand  <= {{WIDTH{1'b0}}, a_cap};
                        mplier <= b_cap;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                CALC: begin
                    if (calc_last) begin
                        ans <= result;
                    end else begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplier_seq.sv
// Self-checking bench for multiplier_seq (WIDTH=6): directed cases,
// back-pressure, reset aborts and randomized transactions.
module tb_multiplier_seq;

    localparam int W  = 6;
    localparam int PW = 2 * W + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          signed_mode;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] ans;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiplier_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A           (a),
        .B           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ans         (ans)
    );

    function automatic logic [PW-1:0] model(
        input logic [W-1:0] ma,
        input logic [W-1:0] mb,
        input logic         ms
    );
        longint p;
        p = longint'(ma) * longint'(mb);
`ifdef MULTIPLIER_SEQ_SIGNED_EN
        if (ms) p = longint'($signed(ma)) * longint'($signed(mb));
`endif
        return p[PW-1:0];
    endfunction

    task automatic check(input string tag, input logic [PW-1:0] obs,
                         input logic [PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb,
                           input logic ts, input int hold, input string tag);
        logic [PW-1:0] exp;
        int n;
        exp = model(ta, tb, ts);
        a = ta;
        b = tb;
        signed_mode = ts;
        in_valid = 1'b1;
        out_ready = 1'b0;
        check({tag, " in_ready"}, PW'(in_ready), PW'(1));
        tick;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        n = 0;
        while (!out_valid && n < 40) begin
            tick;
            n++;
        end
        check({tag, " latency"}, PW'(n), PW'(W + 1));
        check({tag, " ans"}, ans, exp);
        repeat (hold) begin
            in_valid = 1'b1;
            signed_mode = 1'($urandom);
            tick;
            check({tag, " hold out_valid"}, PW'(out_valid), PW'(1));
            check({tag, " hold ans"}, ans, exp);
            check({tag, " hold in_ready"}, PW'(in_ready), PW'(0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick;
        check({tag, " release in_ready"}, PW'(in_ready), PW'(1));
        check({tag, " release out_valid"}, PW'(out_valid), PW'(0));
    endtask

    initial begin
        int seen;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic rs;
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        signed_mode = 1'b0;
        out_ready = 1'b1;
        tick;
        tick;
        rst = 1'b0;
        tick;
        check("reset in_ready", PW'(in_ready), PW'(1));
        check("reset out_valid", PW'(out_valid), PW'(0));
        check("reset ans", ans, '0);

        run_txn(6'd27, 6'd2, 1'b0, 0, "u27x2");
        check("u27x2 const", ans, PW'(54));
        run_txn(6'd63, 6'd63, 1'b0, 0, "u63x63");
        check("u63x63 const", ans, PW'(3969));
        run_txn(6'd63, 6'd42, 1'b0, 0, "u63x42");
        check("u63x42 const", ans, PW'(2646));

        run_txn(6'b111111, 6'b111111, 1'b1, 0, "s-1x-1");
        run_txn(6'b111111, 6'b101010, 1'b1, 0, "s-1x-22");
        run_txn(6'b100000, 6'b011111, 1'b1, 0, "s-32x31");
`ifdef MULTIPLIER_SEQ_SIGNED_EN
        check("s-32x31 const", ans, 13'h1C20);
`else
        check("s-32x31 const", ans, PW'(992));
`endif
        run_txn(6'b100000, 6'b100000, 1'b1, 0, "s-32x-32");
        run_txn(6'd0, 6'b100001, 1'b1, 0, "s0xneg");

        run_txn(6'd45, 6'd19, 1'b0, 5, "bp");

        a = 6'd27;
        b = 6'd2;
        signed_mode = 1'b0;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("abort in_ready", PW'(in_ready), PW'(1));
        check("abort out_valid", PW'(out_valid), PW'(0));
        check("abort ans", ans, '0);
        seen = 0;
        repeat (12) begin
            tick;
            if (out_valid) seen++;
        end
        check("abort no result", PW'(seen), PW'(0));
        run_txn(6'd5, 6'd5, 1'b0, 0, "u5x5");
        check("u5x5 const", ans, PW'(25));

        a = 6'd9;
        b = 6'd9;
        in_valid = 1'b1;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        in_valid = 1'b0;
        check("rst wins in_ready", PW'(in_ready), PW'(1));
        tick;
        check("rst wins out_valid", PW'(out_valid), PW'(0));

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            run_txn(ra, rb, rs, int'($urandom_range(0, 2)), "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multiplier_seq.md
# multiplier_seq

Parametrised sequential shift-add multiplier, the multi-cycle successor to the team's 6-bit combinational multiplier. It accepts one operand pair per transaction over a valid/ready handshake and iterates one multiplier bit per clock. It returns a sign-extended 2*WIDTH+1-bit product, computed as unsigned or two's-complement signed per transaction. It sits between operand producers and result consumers where area matters more than throughput.

## Interface
- WIDTH, default 6: operand width in bits, legal range 2..32.
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand pair on A/B/signed_mode is valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- A  input  WIDTH  multiplicand.
- B  input  WIDTH  multiplier.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with A/B.
- out_valid  output  1  ans holds a completed product.
- out_ready  input  1  consumer accepts ans.
- ans  output  2*WIDTH+1  product; top bit is sign extension (signed) or 0 (unsigned).

## Operation
- States: IDLE, CALC, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready, go to CALC and clear the accumulator and iteration counter.
  - Unsigned: capture A and B as-is.
  - Signed: capture |A| and |B|, and register neg = A[W-1]^B[W-1].
- CALC: each cycle, if current LSB of the multiplier register is 1, add the multiplicand (zero-extended to 2*WIDTH) to the accumulator. Shift the multiplicand left by 1 and the multiplier right by 1, and increment the counter. After exactly WIDTH iterations, go to DONE.
- On entry to DONE, load ans:
  - Unsigned: {1'b0, acc}.
  - Signed: if neg, the two's complement of {1'b0, acc} over 2*WIDTH+1 bits; otherwise {1'b0, acc}.
- DONE: out_valid=1 and ans held stable. On out_valid&&out_ready, return to IDLE. ans keeps its value until the next DONE entry.
- Inputs are ignored outside IDLE, and in_valid during CALC/DONE is not accepted. There is no overlap between transactions.
- Arithmetic is exact for all inputs, including the most-negative operand: |-2^(W-1)| = 2^(W-1) fits in WIDTH bits unsigned.
- Reset, at any time including mid-CALC or during DONE, aborts the transaction without emitting a result.

## Timing
- Reset values, after the first rising edge with rst=1: state=IDLE, in_ready=1, out_valid=0, ans=0, internal registers 0.
- in_ready and out_valid decode from state only, with no combinational path from in_valid/out_ready.
- Acceptance edge is cycle 0. CALC occupies cycles 1..WIDTH. out_valid rises after edge WIDTH+1, so latency is WIDTH+1 cycles.
- With out_ready held high: in_ready returns 1 one cycle after out_valid's first cycle, giving a throughput of one product per WIDTH+2 cycles.
- Back-pressure: out_valid stays high and ans is unchanged for any number of cycles while out_ready=0.
- rst and a handshake asserted on the same edge: rst wins.

## Configuration
- MULTIPLIER_SEQ_SIGNED_EN defined: signed_mode is honoured, and the abs/neg capture and final negation logic are built.
- Not defined: the signed_mode port remains but is ignored. All transactions are unsigned, ans[2*WIDTH]=0, and no negation logic is synthesised.
- Latency is identical in both builds.

## Structure
- Shared package multiplier_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - localparam-style helpers for product width (2*WIDTH+1) and counter width ($clog2(WIDTH+1)).
- Single module; no sub-module is warranted. The datapath is one accumulator, two shift registers and a counter.

## Test plan
- Reset: hold rst 2 cycles, then release -> in_ready=1, out_valid=0, ans=0.
- WIDTH=6, unsigned A=27, B=2 -> out_valid exactly 7 cycles after acceptance, ans=54.
- WIDTH=6, unsigned A=63, B=63 -> ans=3969. Then A=63, B=42 -> ans=2646.
- WIDTH=6, signed (with MULTIPLIER_SEQ_SIGNED_EN):
  - A=6'b111111, B=6'b111111 -> ans=1.
  - A=6'b111111, B=6'b101010 -> ans=22.
  - A=6'b100000, B=6'b011111 -> ans=-992, i.e. 13'h1C20.
- Back-pressure: out_ready=0 for 5 cycles after out_valid -> ans and out_valid stable, in_ready=0, and a new in_valid is not accepted. Then out_ready=1 -> in_ready=1 next cycle.
- Reset mid-CALC: assert rst at cycle 3 of a transaction -> out_valid never rises for it, in_ready=1 after reset. A fresh 5x5 then yields 25.
